bip_debug_ctrl: RTL and testbench

//   Host-side sequencer for the accumulator CPU. Takes byte commands from a serial RX

---
 rtl/bip_debug_if.sv | 36 +++
 rtl/bip_debug_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_bip_debug_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bip_debug_if.sv
// Byte-stream, program-memory and CPU-control bundle between the debug sequencer
// and its surroundings (UART byte streams, program memory, CPU core).
//   rx_data/rx_valid   command and payload bytes from the host
//   tx_data/tx_valid   report bytes towards the host, tx_ready accepts
//   prog_*             program-memory write port
//   cpu_en/cpu_reset   CPU clock enable and reset
//   instr/pc/acc       CPU fetch word, program counter and accumulator
// master: the sequencer view; slave: the view of the surrounding system.
interface bip_debug_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 16
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_wdata;
    logic              cpu_en;
    logic              cpu_reset;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] acc;

    modport master (
        input  rx_data, rx_valid, tx_ready, instr, pc, acc,
        output tx_data, tx_valid, prog_we, prog_addr, prog_wdata, cpu_en, cpu_reset
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, instr, pc, acc,
        input  tx_data, tx_valid, prog_we, prog_addr, prog_wdata, cpu_en, cpu_reset
    );
endinterface

// File: rtl/bip_debug_ctrl.sv
// Host-side sequencer for the accumulator CPU. Decodes byte commands from the RX
// stream: 'L' loads program words, 'R' runs to HLT, 'S' single-steps. Every run or
// step ends with a 6-byte big-endian report {pc, acc, cycle count} on the TX stream.
//   clk     system clock, rising edge
//   reset   asynchronous, active-high
//   bus     bip_debug_if master view (rx/tx byte streams, program write port,
//           CPU enable/reset, CPU fetch/pc/acc observation)
// cpu_en is the only combinational output; everything else leaves a flop.
module bip_debug_ctrl #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic        clk,
    input  logic        reset,
    bip_debug_if.master bus
);

    localparam int unsigned OP_W   = 5;
    localparam int unsigned FLD_W  = 16;
    localparam int unsigned RPT_W  = 3 * FLD_W;
    localparam logic [7:0]  CMD_LOAD  = 8'h4C;
    localparam logic [7:0]  CMD_RUN   = 8'h52;
    localparam logic [7:0]  CMD_STEP  = 8'h53;
    localparam logic [2:0]  LAST_BYTE = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_HI,
        LOAD_LO,
        WRITE,
        RUN,
        STEP,
        REPORT
    } state_t;

    state_t             state_q, state_d;
    logic               entry_q, entry_d;
    logic               halted_q, halted_d;
    logic               armed_q, armed_d;
    logic               cpu_reset_q, cpu_reset_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               we_q, we_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [2:0]         idx_q, idx_d;
    logic [RPT_W-1:0]   snap_q, snap_d;

    logic [OP_W-1:0]    opcode;
    logic               cpu_en_c;
    logic [RPT_W-1:0]   live_rpt;
    logic [5:0]         byte_sh;
    logic               unused_instr;

    assign opcode       = bus.instr[DATA_W-1 -: OP_W];
    assign unused_instr = ^bus.instr[DATA_W-OP_W-1:0];

    // Report image taken from the live CPU state; zero-extends the pc field
    assign live_rpt = {FLD_W'(bus.pc), FLD_W'(bus.acc), FLD_W'(cnt_q)};

    // Bit offset of report byte idx_q counted from the MSB end
    assign byte_sh = 6'(6'd40 - {idx_q, 3'b000});

    // The first cycle of RUN/STEP lets the CPU leave reset; no instruction then
    assign cpu_en_c = ((state_q == RUN) || (state_q == STEP)) && !entry_q && !halted_q
                      && armed_q && !cpu_reset_q && (opcode != '0);

    assign bus.cpu_en     = cpu_en_c;
    assign bus.cpu_reset  = cpu_reset_q;
    assign bus.prog_we    = we_q;
    assign bus.prog_addr  = addr_q;
    assign bus.prog_wdata = wdata_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.tx_data    = tx_data_q;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            entry_q     <= 1'b0;
            halted_q    <= 1'b0;
            armed_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            idx_q       <= '0;
            snap_q      <= '0;
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            halted_q    <= halted_d;
            armed_q     <= armed_d;
            cpu_reset_q <= cpu_reset_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
        end
    end

    // Next-state and next-register logic
    always_comb begin
        state_d     = state_q;
        entry_d     = 1'b0;
        halted_d    = halted_q;
        armed_d     = armed_q;
        cpu_reset_d = cpu_reset_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        idx_d       = idx_q;
        snap_d      = snap_q;

        case (state_q)
            IDLE: begin
                if (bus.rx_valid) begin
                    case (bus.rx_data)
                        CMD_LOAD: begin
                            state_d     = LOAD_HI;
                            addr_d      = '0;
                            cnt_d       = '0;
                            halted_d    = 1'b0;
                            armed_d     = 1'b0;
                            cpu_reset_d = 1'b1;
                        end
                        CMD_RUN, CMD_STEP: begin
                            state_d     = (bus.rx_data == CMD_RUN) ? RUN : STEP;
                            entry_d     = 1'b1;
                            armed_d     = 1'b1;
                            cpu_reset_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end

            LOAD_HI: begin
                if (bus.rx_valid) begin
                    wdata_d = DATA_W'({bus.rx_data, wdata_q[7:0]});
                    state_d = LOAD_LO;
                end
            end

            LOAD_LO: begin
                if (bus.rx_valid) begin
                    wdata_d = DATA_W'({wdata_q[15:8], bus.rx_data});
                    we_d    = 1'b1;
                    state_d = WRITE;
                end
            end

            // The write strobe is high during this state; HLT or the top address ends the load
            WRITE: begin
                if ((wdata_q == '0) || (addr_q == '1)) begin
                    state_d = IDLE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = LOAD_HI;
                end
            end

            RUN: begin
                if (entry_q) begin
                    if (halted_q) begin
                        state_d = REPORT;
                    end
                end else if (opcode == '0) begin
                    halted_d = 1'b1;
                    state_d  = REPORT;
                end
            end

            STEP: begin
                if (entry_q) begin
                    if (halted_q) begin
                        state_d = REPORT;
                    end
                end else begin
                    if (opcode == '0) begin
                        halted_d = 1'b1;
                    end
                    state_d = REPORT;
                end
            end

            // Byte 0 is offered straight from the live image while it is snapshotted
            REPORT: begin
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    if (idx_q == '0) begin
                        snap_d    = live_rpt;
                        tx_data_d = live_rpt[RPT_W-1 -: 8];
                    end else begin
                        tx_data_d = 8'(snap_q >> byte_sh);
                    end
                end else if (bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (idx_q == LAST_BYTE) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // Executed-cycle counter, saturating
        if (cpu_en_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_bip_debug_ctrl.sv
// Directed bench for bip_debug_ctrl: a small accumulator-CPU and program-memory
// model sits on the slave side; expected reports are hand-computed constants.
module tb_bip_debug_ctrl;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bip_debug_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bip_debug_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // CPU model: op 2 = load imm, op 5 = xor imm, op 1 = add imm; memory is system RAM
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] m_pc;
    logic [DATA_W-1:0] m_acc;
    logic [DATA_W-1:0] imm;

    assign bus.instr = mem[m_pc];
    assign bus.pc    = m_pc;
    assign bus.acc   = m_acc;
    assign imm       = 16'(bus.instr[10:0]);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc  <= '0;
            m_acc <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else begin
            if (bus.prog_we) mem[bus.prog_addr] <= bus.prog_wdata;
            if (bus.cpu_reset) begin
                m_pc  <= '0;
                m_acc <= '0;
            end else if (bus.cpu_en) begin
                m_pc <= m_pc + 11'd1;
                case (bus.instr[15:11])
                    5'd1:    m_acc <= m_acc + imm;
                    5'd2:    m_acc <= imm;
                    5'd5:    m_acc <= m_acc ^ imm;
                    default: ;
                endcase
            end
        end
    end

    // Event monitors
    int en_cnt = 0;
    int hs_cnt = 0;
    logic [ADDR_W-1:0] wa_q [$];
    logic [DATA_W-1:0] wd_q [$];

    always @(posedge clk) begin
        if (bus.prog_we) begin
            wa_q.push_back(bus.prog_addr);
            wd_q.push_back(bus.prog_wdata);
        end
        if (bus.cpu_en) en_cnt++;
        if (bus.tx_valid && bus.tx_ready) hs_cnt++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [15:0] prog [4] = '{16'h1001, 16'h2805, 16'h0808, 16'h0000};

    task automatic load_prog();
        send(8'h4C);
        for (int i = 0; i < 4; i++) begin
            send(prog[i][15:8]);
            send(prog[i][7:0]);
        end
    endtask

    // Collects nbytes report bytes, holding tx_ready low for stall cycles per byte
    task automatic get_report(input int nbytes, input int stall, output logic [47:0] r);
        int n;
        logic [7:0] d;
        logic stable;
        r = '0;
        for (int k = 0; k < nbytes; k++) begin
            n = 0;
            while (!bus.tx_valid && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            check_eq("tx_byte_offered", 64'(bus.tx_valid), 64'd1);
            if (!bus.tx_valid) return;
            d = bus.tx_data;
            stable = 1'b1;
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                if (!bus.tx_valid || bus.tx_data !== d) stable = 1'b0;
            end
            if (stall > 0) check_eq("tx_stable", 64'(stable), 64'd1);
            r = {r[39:0], d};
            bus.tx_ready = 1'b1;
            @(posedge clk); #1;
            bus.tx_ready = 1'b0;
        end
    endtask

    // Issues R or S, checks the report and the number of enabled CPU cycles
    task automatic cmd_report(input string tag, input logic [7:0] cmd, input int stall,
                              input logic [47:0] exp, input int exp_en);
        int en0;
        int hs0;
        logic [47:0] r;
        logic extra;
        en0 = en_cnt;
        hs0 = hs_cnt;
        send(cmd);
        get_report(6, stall, r);
        check_eq({tag, "_report"}, 64'(r), 64'(exp));
        check_eq({tag, "_en_cycles"}, 64'(en_cnt - en0), 64'(exp_en));
        extra = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.tx_valid) extra = 1'b1;
        end
        check_eq({tag, "_no_extra_byte"}, 64'(extra), 64'd0);
        check_eq({tag, "_handshakes"}, 64'(hs_cnt - hs0), 64'd6);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1);
    end

    initial begin
        int base;
        int bad;
        int en0;
        int hs0;
        int n;
        logic [47:0] r;

        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tx_valid",   64'(bus.tx_valid),   64'd0);
        check_eq("rst_tx_data",    64'(bus.tx_data),    64'd0);
        check_eq("rst_prog_we",    64'(bus.prog_we),    64'd0);
        check_eq("rst_prog_addr",  64'(bus.prog_addr),  64'd0);
        check_eq("rst_prog_wdata", 64'(bus.prog_wdata), 64'd0);
        check_eq("rst_cpu_en",     64'(bus.cpu_en),     64'd0);
        check_eq("rst_cpu_reset",  64'(bus.cpu_reset),  64'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        // Unknown command byte is ignored
        send(8'h41);
        repeat (4) @(posedge clk);
        #1;
        check_eq("ign_writes",  64'(wa_q.size()), 64'd0);
        check_eq("ign_tx",      64'(bus.tx_valid), 64'd0);
        check_eq("ign_cpu_en",  64'(en_cnt), 64'd0);

        // Program load
        load_prog();
        check_eq("load_writes", 64'(wa_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            check_eq("load_addr", 64'(wa_q[i]), 64'(i));
            check_eq("load_data", 64'(wd_q[i]), 64'(prog[i]));
        end
        check_eq("load_cpu_reset", 64'(bus.cpu_reset), 64'd1);

        // Run to HLT: 3 instructions, acc = 1 ^ 5 + 8 = 0x0C
        cmd_report("run", 8'h52, 0, 48'h0003_000C_0003, 3);

        // Single steps after a fresh load
        load_prog();
        cmd_report("step1", 8'h53, 0, 48'h0001_0001_0001, 1);
        cmd_report("step2", 8'h53, 0, 48'h0002_0004_0002, 1);
        cmd_report("step3", 8'h53, 0, 48'h0003_000C_0003, 1);
        cmd_report("step4", 8'h53, 0, 48'h0003_000C_0003, 0);

        // Already halted: immediate report under TX backpressure
        cmd_report("bp", 8'h52, 5, 48'h0003_000C_0003, 0);

        // Address-space overflow load
        base = wa_q.size();
        send(8'h4C);
        for (int i = 0; i < int'(DEPTH); i++) begin
            send(8'h08);
            send(8'(i));
        end
        check_eq("ovf_writes", 64'(wa_q.size() - base), 64'(DEPTH));
        bad = 0;
        for (int i = 0; i < int'(DEPTH) && (base + i) < wa_q.size(); i++) begin
            if (wa_q[base + i] !== 11'(i)) bad++;
            if (wd_q[base + i] !== {8'h08, 8'(i)}) bad++;
        end
        check_eq("ovf_sequence", 64'(bad), 64'd0);
        check_eq("ovf_last_addr", 64'(wa_q[wa_q.size() - 1]), 64'h7FF);
        send(8'h12);
        send(8'h34);
        repeat (3) @(posedge clk);
        #1;
        check_eq("ovf_no_wrap", 64'(wa_q.size() - base), 64'(DEPTH));
        check_eq("ovf_cpu_reset", 64'(bus.cpu_reset), 64'd1);

        // Reset in the middle of a run
        load_prog();
        send(8'h52);
        check_eq("midrun_en", 64'(bus.cpu_en), 64'd1);
        reset = 1'b1;
        #1;
        check_eq("midrun_rst_cpu_en",    64'(bus.cpu_en),    64'd0);
        check_eq("midrun_rst_cpu_reset", 64'(bus.cpu_reset), 64'd1);
        check_eq("midrun_rst_tx_valid",  64'(bus.tx_valid),  64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Run without reload: RAM cleared, HLT fetched at once, count 0; abandon after byte 3
        en0 = en_cnt;
        hs0 = hs_cnt;
        send(8'h52);
        get_report(3, 0, r);
        check_eq("part_bytes", 64'(r[23:0]), 64'd0);
        n = 0;
        while (!bus.tx_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("part_byte4_offered", 64'(bus.tx_valid), 64'd1);
        reset = 1'b1;
        #1;
        check_eq("midrpt_rst_tx_valid",  64'(bus.tx_valid),  64'd0);
        check_eq("midrpt_rst_tx_data",   64'(bus.tx_data),   64'd0);
        check_eq("midrpt_rst_cpu_reset", 64'(bus.cpu_reset), 64'd1);
        check_eq("midrpt_handshakes", 64'(hs_cnt - hs0), 64'd3);
        check_eq("midrpt_en_cycles",  64'(en_cnt - en0), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        cmd_report("post_rst", 8'h52, 0, 48'h0000_0000_0000, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
